config_tx: RTL and testbench

Serial configuration transmitter for the NanEye image sensor link. On a request from the receive decoder it sends a fixed-length configuration word MSB-first on a data/clock pair with output enable, then reports completion. It sits between the RX decoder's configuration request and the sensor's bidirectional pad drivers. It runs in the system clock domain. The measured line period can delay transmission so it lands in the sensor's configuration window.

---
 rtl/config_tx.sv | 150 +++++++++++++++
 tb/tb_config_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/config_tx.sv
// NanEye configuration transmitter: serialises one config word MSB-first on TX_DAT/TX_CLK.
// Optional pre-transfer line delay is enabled with CONFIG_TX_LINE_DELAY_EN.
module config_tx #(
    parameter int CLOCK_PERIOD_PS = 20833,
    parameter int BIT_PERIOD_NS   = 400,
    parameter int C_NO_CFG_BITS   = 24
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [15:0]              LINE_PERIOD,
    input  logic [C_NO_CFG_BITS-1:0] INPUT,
    output logic                     TX_END,
    output logic                     TX_DAT,
    output logic                     TX_CLK,
    output logic                     TX_OE
);

    localparam int BIT_RAW    = (BIT_PERIOD_NS * 1000) / CLOCK_PERIOD_PS;
    localparam int BIT_CYCLES = (BIT_RAW < 2) ? 2 : BIT_RAW;
    localparam int LO_CYCLES  = BIT_CYCLES / 2;
    localparam int PW         = $clog2(BIT_CYCLES + 1);
    localparam int BW         = $clog2(C_NO_CFG_BITS + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] PH_LO    = PW'(LO_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(C_NO_CFG_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef CONFIG_TX_LINE_DELAY_EN
        WAIT  = 2'd1,
`endif
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic                     start_q;
    logic                     armed;
    logic                     req;
    logic                     accept;
    logic                     bit_end;
    logic [C_NO_CFG_BITS-1:0] shreg;
    logic [PW-1:0]            phase;
    logic [BW-1:0]            bit_cnt;

`ifdef CONFIG_TX_LINE_DELAY_EN
    logic [15:0]              delay;
`else
    logic                     unused_line_period;
    assign unused_line_period = ^LINE_PERIOD;
`endif

    // armed blocks a START that was already high when reset was released
    assign req = START & ~start_q & armed;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        bit_end = 1'b0;
        TX_END  = 1'b0;
        TX_DAT  = 1'b0;
        TX_CLK  = 1'b0;
        TX_OE   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
`ifdef CONFIG_TX_LINE_DELAY_EN
                    state_n = (LINE_PERIOD == 16'd0) ? SHIFT : WAIT;
`else
                    state_n = SHIFT;
`endif
                end
            end
`ifdef CONFIG_TX_LINE_DELAY_EN
            WAIT: begin
                if (delay == 16'd1) begin
                    state_n = SHIFT;
                end
            end
`endif
            SHIFT: begin
                TX_OE  = 1'b1;
                TX_DAT = shreg[C_NO_CFG_BITS-1];
                TX_CLK = (phase >= PH_LO);
                if (phase == PH_LAST) begin
                    bit_end = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                TX_END  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= IDLE;
            start_q <= 1'b0;
            armed   <= ~START;
        end else begin
            state   <= state_n;
            start_q <= START;
            armed   <= armed | ~START;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            shreg   <= '0;
            phase   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= INPUT;
            phase   <= '0;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                phase   <= '0;
                shreg   <= {shreg[C_NO_CFG_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                phase   <= phase + 1'b1;
            end
        end
    end

`ifdef CONFIG_TX_LINE_DELAY_EN
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            delay <= '0;
        end else if (accept) begin
            delay <= LINE_PERIOD;
        end else if (state == WAIT) begin
            delay <= delay - 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_config_tx.sv
// Directed bench for config_tx: reset, basic word, delay, retrigger, mid reset, held START.
module tb_config_tx;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] LINE_PERIOD;
    logic [23:0] INPUT;
    logic        TX_END;
    logic        TX_DAT;
    logic        TX_CLK;
    logic        TX_OE;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    config_tx dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .START       (START),
        .LINE_PERIOD (LINE_PERIOD),
        .INPUT       (INPUT),
        .TX_END      (TX_END),
        .TX_DAT      (TX_DAT),
        .TX_CLK      (TX_CLK),
        .TX_OE       (TX_OE)
    );

    // line observer: counts edges and pulses, captures bits on TX_CLK rise
    int          rises     = 0;
    int          bad_rises = 0;
    int          ends      = 0;
    int          end_bad   = 0;
    int          dat_bad   = 0;
    int          sh_idx    = 0;
    int          pos       = 0;
    int          oe_len    = 0;
    logic [23:0] cap       = '0;
    logic        prev_clk  = 1'b0;
    logic        prev_oe   = 1'b0;
    logic        prev_dat  = 1'b0;

    always @(negedge CLOCK) begin
        pos = sh_idx;
        if (TX_OE === 1'b1) sh_idx = sh_idx + 1;
        if (TX_CLK === 1'b1 && prev_clk === 1'b0) begin
            rises = rises + 1;
            cap   = {cap[22:0], TX_DAT};
            if ((pos % 19) != 9) bad_rises = bad_rises + 1;
        end
        if (TX_CLK === 1'b1 && prev_clk === 1'b1 && TX_DAT !== prev_dat)
            dat_bad = dat_bad + 1;
        if (TX_OE !== 1'b1) begin
            if (prev_oe === 1'b1) oe_len = sh_idx;
            sh_idx = 0;
        end
        if (TX_END === 1'b1) begin
            ends = ends + 1;
            if (prev_oe !== 1'b1 || TX_OE !== 1'b0) end_bad = end_bad + 1;
        end
        prev_clk = TX_CLK;
        prev_oe  = TX_OE;
        prev_dat = TX_DAT;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_end(output int k);
        k = 0;
        while (TX_END !== 1'b1 && k < 1000) begin
            step(1);
            k++;
        end
    endtask

    task automatic kick();
        START = 1'b0;
        step(2);
        START = 1'b1;
        step(1);
    endtask

    int k;
    int d;
    int base_r;
    int base_e;
    int exp_d;

    initial begin
        RESET       = 1'b1;
        START       = 1'b1;
        LINE_PERIOD = 16'd0;
        INPUT       = 24'hAEC9EC;

        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rst_out", {28'd0, TX_END, TX_DAT, TX_CLK, TX_OE}, 32'd0);
        end
        RESET = 1'b0;
        step(20);
        check("held_after_rst_ends", ends, 0);
        check("held_after_rst_oe", {31'd0, TX_OE}, 32'd0);

        // basic transfer
        base_r = rises;
        base_e = ends;
        kick();
        check("oe_first", {31'd0, TX_OE}, 32'd1);
        wait_end(k);
        check("end_cycle", k, 456);
        step(2);
        check("oe_len", oe_len, 456);
        check("rises", rises - base_r, 24);
        check("rise_pos", bad_rises, 0);
        check("word", cap, 32'hAEC9EC);
        check("ends", ends - base_e, 1);
        check("end_vs_oe", end_bad, 0);
        check("dat_stable", dat_bad, 0);

        // pre-transfer delay
`ifdef CONFIG_TX_LINE_DELAY_EN
        exp_d = 100;
`else
        exp_d = 0;
`endif
        LINE_PERIOD = 16'd100;
        INPUT       = 24'h5A0F3C;
        kick();
        LINE_PERIOD = 16'd3;
        d = 0;
        while (TX_OE !== 1'b1 && d < 300) begin
            step(1);
            d++;
        end
        check("delay", d, exp_d);
        wait_end(k);
        check("delay_end_seen", {31'd0, TX_END}, 32'd1);
        step(2);
        check("delay_word", cap, 32'h5A0F3C);
        check("delay_len", oe_len, 456);

        // retrigger during SHIFT is ignored
        LINE_PERIOD = 16'd0;
        INPUT       = 24'h3CA581;
        base_e      = ends;
        kick();
        step(50);
        START = 1'b0;
        INPUT = 24'hFFFFFF;
        step(2);
        START = 1'b1;
        wait_end(k);
        check("retrig_end_seen", {31'd0, TX_END}, 32'd1);
        step(6);
        check("retrig_word", cap, 32'h3CA581);
        check("retrig_ends", ends - base_e, 1);
        check("retrig_idle_oe", {31'd0, TX_OE}, 32'd0);

        // reset at bit 10
        INPUT  = 24'h123456;
        kick();
        step(10 * 19);
        RESET = 1'b1;
        step(1);
        check("rst_mid_out", {28'd0, TX_END, TX_DAT, TX_CLK, TX_OE}, 32'd0);
        base_e = ends;
        RESET  = 1'b0;
        step(5);
        check("rst_mid_noend", ends - base_e, 0);
        kick();
        check("rst_mid_restart", {31'd0, TX_OE}, 32'd1);
        wait_end(k);
        check("rst_mid_end_cycle", k, 456);
        step(2);
        check("rst_mid_word", cap, 32'h123456);
        check("rst_mid_ends", ends - base_e, 1);

        // START held for 2000 cycles
        INPUT  = 24'hC0FFEE;
        base_r = rises;
        base_e = ends;
        kick();
        step(2000);
        check("held_ends", ends - base_e, 1);
        check("held_rises", rises - base_r, 24);
        check("held_word", cap, 32'hC0FFEE);
        check("held_rise_pos", bad_rises, 0);
        check("held_end_vs_oe", end_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
